// File: rtl/seg7_scan_ctrl.sv
// rtl/seg7_scan_ctrl.sv - 8-digit multiplexed seven-segment controller with byte-lane display register
// Optional leading-zero blanking: define SEG7_LEADING_ZERO_BLANK_EN.
module seg7_scan_ctrl #(
    parameter int SCAN_DIV = 50000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] addr,
    input  logic [3:0]  we,
    input  logic [31:0] wdata,
    output logic [7:0]  dig_en,
    output logic [7:0]  seg
);
    localparam int DIV_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;

    logic [31:0]      disp;
    logic [DIV_W-1:0] div;
    logic [2:0]       idx;
    logic             tick;
    logic [3:0]       nib;
    logic [7:0]       dec;
    logic             blank;

    // The bridge has already decoded the address; it is kept only for port compatibility.
    logic unused_addr;
    assign unused_addr = ^addr;

    assign tick = (div == DIV_W'(SCAN_DIV - 1));
    assign nib  = disp[{idx, 2'b00} +: 4];

    always_comb begin
        dec = 8'hFF;
        case (nib)
            4'h0: dec = 8'hC0;
            4'h1: dec = 8'hF9;
            4'h2: dec = 8'hA4;
            4'h3: dec = 8'hB0;
            4'h4: dec = 8'h99;
            4'h5: dec = 8'h92;
            4'h6: dec = 8'h82;
            4'h7: dec = 8'hF8;
            4'h8: dec = 8'h80;
            4'h9: dec = 8'h90;
            4'hA: dec = 8'h88;
            4'hB: dec = 8'h83;
            4'hC: dec = 8'hC6;
            4'hD: dec = 8'hA1;
            4'hE: dec = 8'h86;
            4'hF: dec = 8'h8E;
            default: dec = 8'hFF;
        endcase
    end

`ifdef SEG7_LEADING_ZERO_BLANK_EN
    // A digit is a leading zero when it and everything above it is zero; digit 0 always shows.
    always_comb begin
        blank = (idx != 3'd0) && ((disp >> {idx, 2'b00}) == 32'd0);
    end
`else
    always_comb begin
        blank = 1'b0;
    end
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            disp   <= 32'd0;
            div    <= '0;
            idx    <= 3'd0;
            dig_en <= 8'hFF;
            seg    <= 8'hFF;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (we[i]) begin
                    disp[8*i +: 8] <= wdata[8*i +: 8];
                end
            end
            if (tick) begin
                div <= '0;
                idx <= idx + 3'd1;
            end else begin
                div <= div + 1'b1;
            end
            // Both outputs come from the same idx/disp snapshot so they never disagree on digit.
            dig_en <= ~(8'b1 << idx);
            seg    <= blank ? 8'hFF : dec;
        end
    end
endmodule

// File: doc/seg7_scan_ctrl.md
# seg7_scan_ctrl

Memory-mapped 8-digit seven-segment display controller sitting directly downstream of the CPU peripheral bridge on the 7-seg port. It holds a 32-bit display word written by CPU stores that the bridge has already address-decoded into byte write enables. It time-multiplexes the word as eight hex digits onto common-anode LED segments.

## Interface
Parameters:
- SCAN_DIV, 50000, clock cycles each digit stays lit; legal range 2..2^20.

Ports:
- clk  in  1  system clock, same clock as the CPU.
- rst  in  1  reset, synchronous, active-low.
- addr  in  32  bus address from the bridge; not decoded here.
- we  in  4  byte write enables, already gated by the bridge; bit i writes lane i.
- wdata  in  32  store data.
- dig_en  out  8  digit anode enables, active-low; bit k selects digit k, where digit 0 is the rightmost.
- seg  out  8  segments {DP,G,F,E,D,C,B,A}, active-low.

## Operation
- **Display register** `disp[31:0]`:
  - For each lane i where we[i]=1, disp[8i+7:8i] <= wdata[8i+7:8i] at the clock edge.
  - Lanes with we[i]=0 hold their value.
  - we=4'b0000 is a no-op.
- **Scan divider** `div`:
  - Counts 0..SCAN_DIV-1 and wraps to 0.
  - The terminal count `tick` occurs at div==SCAN_DIV-1.
- **Digit index** `idx[2:0]`:
  - Increments on tick.
  - Wraps 7 -> 0.
- **Outputs** (registered every cycle):
  - dig_en <= ~(8'b1 << idx).
  - seg <= decode(disp[4*idx+3:4*idx]).
  - DP (seg[7]) is always 1 (off).
- **Decode** (active-low):
  - 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8
  - 8=80, 9=90, A=88, b=83, C=C6, d=A1, E=86, F=8E
- Exactly one dig_en bit is low at any time after the first post-reset edge.

## Timing
- **Reset** (rst=0 sampled at an edge):
  - disp=0, div=0, idx=0, dig_en=8'hFF (all off), seg=8'hFF.
  - Reset mid-scan aborts immediately; scanning restarts at digit 0 with a full SCAN_DIV period.
- **First edge after reset release:** dig_en=8'hFE, seg=8'hC0.
- **Write-to-display latency:**
  - A write at edge N updates disp at N.
  - If the written nibble belongs to the current digit, seg reflects it at edge N+1.
  - Otherwise it appears when that digit is next scanned.
- **Digit switch latency:** tick at edge N advances idx at N; dig_en and seg change together at N+1. There is no cycle where dig_en and seg belong to different digits.
- **Dwell time:** each digit is lit for exactly SCAN_DIV cycles; a full frame is 8*SCAN_DIV cycles.
- **Write coinciding with tick:** both take effect. The next seg is decoded from the new idx and the new disp.
- **Simultaneous writes:** partial-lane writes never disturb other lanes or the scan counters.

## Configuration
- Macro `SEG7_LEADING_ZERO_BLANK_EN`.
- **Defined:** leading-zero blanking is enabled.
  - A digit k>0 is blanked (seg=8'hFF) when disp[31:4k] is all zero.
  - dig_en still scans normally.
  - Digit 0 is never blanked.
  - Blanking is evaluated from the same disp value used for decode, so it has the same latency.
- **Undefined:** all eight digits always show their hex value, including leading zeros.

## Test plan
All scenarios use SCAN_DIV=4.

1. **Reset:** hold rst=0 for 3 cycles, then release.
   - While in reset: dig_en=FF, seg=FF.
   - First edge after release: dig_en=FE, seg=C0.
   - dig_en becomes FD after 4 cycles.
2. **Full write and scan:** we=F, wdata=32'h89AB_CDEF, then run 32 cycles.
   - Digits 0..7 show 8E, 86, A1, C6, 83, 88, 90, 80.
   - dig_en follows FE, FD, FB, F7, EF, DF, BF, 7F.
   - idx wraps back to FE.
3. **Byte-lane write:** preload 32'h1234_5678, then write we=4'b0100, wdata=32'hFF00_0000.
   - disp becomes 32'h1200_5678.
   - Digit 4 shows C0 and digit 5 shows C0.
4. **Write to live digit:** while digit 0 is lit, write lane 0 with 0x07.
   - seg changes to F8 on the next edge.
   - dig_en is unchanged.
5. **Mid-scan reset:** assert rst=0 while idx=5.
   - Next edge: dig_en=FF, seg=FF, disp=0.
   - After release, the scan restarts at FE.
6. **Leading-zero blanking:** with `SEG7_LEADING_ZERO_BLANK_EN` defined, write 32'h0000_0A05.
   - Digits 0..2 show 92, C0, 88.
   - Digits 3..7 show FF.
   - With disp=0, digit 0 shows C0.
